// File: rtl/ntt_bank_scheduler_if.sv
// Control/address bus between the NTT control FSM, the bank scheduler and the datapath.
// NTT_BANK_SCHED_INTT_EN adds the inv request bit.
interface ntt_bank_scheduler_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [6:0] rd_addr0;
    logic [6:0] rd_addr1;
    logic       rd_mode;
    logic [6:0] zeta_idx;
    logic       wr_en;
    logic [6:0] wr_addr0;
    logic [6:0] wr_addr1;
    logic       wr_mode;
`ifdef NTT_BANK_SCHED_INTT_EN
    logic       inv;

    modport master (output start, inv,
                    input  busy, done, rd_en, rd_addr0, rd_addr1, rd_mode, zeta_idx,
                           wr_en, wr_addr0, wr_addr1, wr_mode);
    modport slave  (input  start, inv,
                    output busy, done, rd_en, rd_addr0, rd_addr1, rd_mode, zeta_idx,
                           wr_en, wr_addr0, wr_addr1, wr_mode);
`else
    modport master (output start,
                    input  busy, done, rd_en, rd_addr0, rd_addr1, rd_mode, zeta_idx,
                           wr_en, wr_addr0, wr_addr1, wr_mode);
    modport slave  (input  start,
                    output busy, done, rd_en, rd_addr0, rd_addr1, rd_mode, zeta_idx,
                           wr_en, wr_addr0, wr_addr1, wr_mode);
`endif
endinterface

// File: rtl/ntt_bank_scheduler.sv
// Butterfly address/twiddle sequencer for a 256-point Kyber NTT over two coefficient banks.
// Define NTT_BANK_SCHED_INTT_EN to add the inverse-order sequence selected by bus.inv.
module ntt_bank_scheduler #(
    parameter int PIPE_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ntt_bank_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic [2:0] layer;
    logic [6:0] k;
    logic [3:0] dcnt;
    logic       inv_q;
    logic       busy_q, done_q, rd_en_q, rd_mode_q;
    logic [6:0] rd_a0_q, rd_a1_q, zeta_q;

    logic [2:0] s;
    logic [6:0] mask, half_len, kh, ja, pa, zeta;
    logic [7:0] j;
    logic       bank_j;

    // j keeps k's low s bits and shifts the rest up one, leaving bit s clear for the partner.
    always_comb begin
        s        = inv_q ? 3'(layer + 3'd1) : 3'(3'd7 - layer);
        mask     = (7'd1 << s) - 7'd1;
        half_len = 7'd1 << (s - 3'd1);
        kh       = k >> s;
        j        = {k & ~mask, 1'b0} | {1'b0, k & mask};
        ja       = j[7:1];
        pa       = ja | half_len;
        bank_j   = ^j;
        zeta     = inv_q ? ((7'h7f >> (s - 3'd1)) - kh) : ((7'd1 << layer) + kh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            layer     <= '0;
            k         <= '0;
            dcnt      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_mode_q <= 1'b0;
            rd_a0_q   <= '0;
            rd_a1_q   <= '0;
            zeta_q    <= '0;
`ifdef NTT_BANK_SCHED_INTT_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_mode_q <= 1'b0;
            rd_a0_q   <= '0;
            rd_a1_q   <= '0;
            zeta_q    <= '0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= RUN;
                    layer <= '0;
                    k     <= '0;
`ifdef NTT_BANK_SCHED_INTT_EN
                    inv_q <= bus.inv;
`endif
                end
                RUN: begin
                    busy_q    <= 1'b1;
                    rd_en_q   <= 1'b1;
                    rd_mode_q <= bank_j;
                    rd_a0_q   <= bank_j ? pa : ja;
                    rd_a1_q   <= bank_j ? ja : pa;
                    zeta_q    <= zeta;
                    k         <= k + 7'd1;
                    if (k == 7'd127) begin
                        state <= DRAIN;
                        dcnt  <= 4'(PIPE_LAT - 1);
                    end
                end
                // Hold off the next layer until its last write-back leaves the delay line.
                DRAIN: begin
                    if (dcnt == 4'd0) begin
                        if (layer == 3'd6) begin
                            state <= DONE;
                        end else begin
                            layer <= layer + 3'd1;
                            state <= RUN;
                        end
                    end else begin
                        dcnt <= dcnt - 4'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef NTT_BANK_SCHED_INTT_EN
    assign inv_q = 1'b0;
`endif

    logic [PIPE_LAT-1:0]       vld_pipe;
    logic [PIPE_LAT-1:0][14:0] dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en_q;
            dat_pipe[0] <= {rd_a0_q, rd_a1_q, rd_mode_q};
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr0 = rd_a0_q;
    assign bus.rd_addr1 = rd_a1_q;
    assign bus.rd_mode  = rd_mode_q;
    assign bus.zeta_idx = zeta_q;
    assign bus.wr_en    = vld_pipe[PIPE_LAT-1];
    assign bus.wr_addr0 = dat_pipe[PIPE_LAT-1][14:8];
    assign bus.wr_addr1 = dat_pipe[PIPE_LAT-1][7:1];
    assign bus.wr_mode  = dat_pipe[PIPE_LAT-1][0];
endmodule

// File: tb/tb_ntt_bank_scheduler.sv
// Self-checking bench for ntt_bank_scheduler: arithmetic model of the butterfly schedule,
// per-cycle compare, per-layer coverage and literal pins on the model.
module tb_ntt_bank_scheduler;
    localparam int P    = 4;
    localparam int T    = 128 + P;
    localparam int LAST = 7 * T;

    typedef struct packed {
        logic       busy, done, rd_en;
        logic [6:0] ra0, ra1;
        logic       rm;
        logic [6:0] z;
        logic       wr_en;
        logic [6:0] wa0, wa1;
        logic       wm;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_bank_scheduler_if bus();
    ntt_bank_scheduler #(.PIPE_LAT(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    obs_t log_q [0:LAST+8];

    function automatic obs_t sample();
        obs_t o;
        o.busy = bus.busy;  o.done = bus.done;  o.rd_en = bus.rd_en;
        o.ra0 = bus.rd_addr0; o.ra1 = bus.rd_addr1; o.rm = bus.rd_mode; o.z = bus.zeta_idx;
        o.wr_en = bus.wr_en; o.wa0 = bus.wr_addr0; o.wa1 = bus.wr_addr1; o.wm = bus.wr_mode;
        return o;
    endfunction

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, c, act, exp);
        end
    endtask

    // Schedule straight from the index arithmetic: pair (j, j+len), bank = parity, addr = i/2.
    task automatic rd_model(input int c, input bit inv, output bit v,
                            output int a0, output int a1, output int m, output int z);
        int L, k, s, len, j, p;
        v = 0; a0 = 0; a1 = 0; m = 0; z = 0;
        if (c < 1 || c > LAST) return;
        L = (c - 1) / T;
        k = (c - 1) % T;
        if (k > 127) return;
        s   = inv ? L + 1 : 7 - L;
        len = 1 << s;
        j   = (k / len) * 2 * len + k % len;
        p   = j + len;
        m   = $countones(j) % 2;
        a0  = (m == 0) ? j / 2 : p / 2;
        a1  = (m == 0) ? p / 2 : j / 2;
        z   = inv ? (256 / len) - 1 - k / len : (1 << L) + k / len;
        v   = 1;
    endtask

    task automatic run(input bit inv, input bit reset_mid);
        int   cnt [256];
        obs_t o;
        bit   v, wv;
        int   a0, a1, m, z, wa0, wa1, wm, bad, idx;
        foreach (cnt[i]) cnt[i] = 0;
        @(negedge clk);
        bus.start = 1'b1;
`ifdef NTT_BANK_SCHED_INTT_EN
        bus.inv = inv;
`endif
        @(posedge clk);
        for (int c = 0; c <= LAST + 5; c++) begin
            @(negedge clk);
            // Pulses at 300 (mid-run) and LAST (DONE state) must be ignored.
            bus.start = (c == 299) || (c == LAST);
            if (reset_mid && c == 1 + 3 * T + 10) begin
                #2 rst_n = 1'b0;
                #1 chk("reset_mid_outputs", c, 64'(sample()), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                bus.start = 1'b0;
                return;
            end
            o = sample();
            log_q[c] = o;
            rd_model(c, inv, v, a0, a1, m, z);
            rd_model(c - P, inv, wv, wa0, wa1, wm, z);
            rd_model(c, inv, v, a0, a1, m, z);
            chk("ctrl", c, {o.busy, o.done, o.rd_en, o.wr_en, o.wa0, o.wa1, o.wm},
                {(c >= 1 && c <= LAST), (c == LAST + 1), v, wv, 7'(wa0), 7'(wa1), 1'(wm)});
            if (v) begin
                chk("rd", c, {o.ra0, o.ra1, o.rm, o.z}, {7'(a0), 7'(a1), 1'(m), 7'(z)});
                idx = 2 * o.ra0 + ($countones(o.ra0) % 2);
                cnt[idx]++;
                idx = 2 * o.ra1 + 1 - ($countones(o.ra1) % 2);
                cnt[idx]++;
                if ((c - 1) % T == 127) begin
                    bad = 0;
                    foreach (cnt[i]) begin
                        if (cnt[i] != 1) bad++;
                        cnt[i] = 0;
                    end
                    chk("layer_coverage", c, 64'(bad), 64'd0);
                end
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
`ifdef NTT_BANK_SCHED_INTT_EN
        bus.inv = 1'b0;
`endif
        #12 chk("reset_state", 0, 64'(sample()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 1'b1);
        run(1'b0, 1'b0);

        chk("lit_c1_rd", 1, {log_q[1].rd_en, log_q[1].ra0, log_q[1].ra1, log_q[1].rm, log_q[1].z},
            {1'b1, 7'd0, 7'd64, 1'b0, 7'd1});
        chk("lit_c2_rd", 2, {log_q[2].rd_en, log_q[2].ra0, log_q[2].ra1, log_q[2].rm, log_q[2].z},
            {1'b1, 7'd64, 7'd0, 1'b1, 7'd1});
        chk("lit_c5_wr", 5, {log_q[5].wr_en, log_q[5].wa0, log_q[5].wa1, log_q[5].wm},
            {1'b1, 7'd0, 7'd64, 1'b0});
        chk("lit_c6_wr", 6, {log_q[6].wr_en, log_q[6].wa0, log_q[6].wa1, log_q[6].wm},
            {1'b1, 7'd64, 7'd0, 1'b1});
        chk("lit_l6_last", 920, {log_q[920].rd_en, log_q[920].ra0, log_q[920].ra1, log_q[920].rm, log_q[920].z},
            {1'b1, 7'd127, 7'd126, 1'b1, 7'd127});
        chk("lit_l6_first", 793, {log_q[793].rd_en, log_q[793].ra0, log_q[793].ra1, log_q[793].rm, log_q[793].z},
            {1'b1, 7'd0, 7'd1, 1'b0, 7'd64});
        chk("lit_barrier_rd", 128, {log_q[128].rd_en, log_q[129].rd_en, log_q[132].rd_en, log_q[133].rd_en},
            4'b1001);
        chk("lit_barrier_wr", 132, {log_q[4].wr_en, log_q[5].wr_en, log_q[132].wr_en, log_q[133].wr_en},
            4'b0110);
        chk("lit_done", 925, {log_q[924].done, log_q[925].done, log_q[926].done}, 3'b010);
        chk("lit_busy", 925, {log_q[1].busy, log_q[924].busy, log_q[925].busy}, 3'b110);

`ifdef NTT_BANK_SCHED_INTT_EN
        run(1'b1, 1'b0);
        chk("lit_inv_c1", 1, {log_q[1].ra0, log_q[1].ra1, log_q[1].rm, log_q[1].z},
            {7'd0, 7'd1, 1'b0, 7'd127});
        chk("lit_inv_last_layer", 1 + 6 * T, {log_q[1 + 6 * T].z, log_q[128 + 6 * T].z}, {7'd1, 7'd1});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
